// File: rtl/bpm_rate_strobe_gen.sv
// Run-time configurable turn / PT / FA / SA strobe generator for the ADC clock domain,
// with optional event-system alignment and phase-error capture.
module bpm_rate_strobe_gen #(
  parameter int SPT_WIDTH = 8,
  parameter int TPP_WIDTH = 6,
  parameter int FA_WIDTH  = 10,
  parameter int SA_WIDTH  = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sampleValid,
  input  logic [SPT_WIDTH-1:0] samplesPerTurn,
  input  logic [TPP_WIDTH-1:0] turnsPerPt,
  input  logic [FA_WIDTH-1:0]  faDecimate,
  input  logic [SA_WIDTH-1:0]  saDecimate,
  input  logic [1:0]           syncMode,
  input  logic                 syncArm,
  input  logic                 syncIn,
  output logic                 turnStrobe,
  output logic                 ptStrobe,
  output logic                 faStrobe,
  output logic                 saStrobe,
  output logic [TPP_WIDTH-1:0] ptIndex,
  output logic                 aligned,
  output logic                 syncErr,
  output logic [SPT_WIDTH-1:0] phaseSample,
  output logic [TPP_WIDTH-1:0] phaseTurn
);

  localparam logic [SPT_WIDTH-1:0] SPT_ONE = SPT_WIDTH'(1);
  localparam logic [TPP_WIDTH-1:0] TPP_ONE = TPP_WIDTH'(1);
  localparam logic [FA_WIDTH-1:0]  FA_ONE  = FA_WIDTH'(1);
  localparam logic [SA_WIDTH-1:0]  SA_ONE  = SA_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t state_q, state_d, eff_state;

  logic [SPT_WIDTH-1:0] sample_cnt_q, sample_cnt_d, spt_q, spt_d, spt_in, spt_cfg;
  logic [TPP_WIDTH-1:0] turn_cnt_q, turn_cnt_d, tpp_q, tpp_d, tpp_in, tpp_cfg;
  logic [FA_WIDTH-1:0]  pt_cnt_q, pt_cnt_d, fad_q, fad_d, fad_in, fad_cfg;
  logic [SA_WIDTH-1:0]  fa_cnt_q, fa_cnt_d, sad_q, sad_d, sad_in, sad_cfg;
  logic [3:0]           strobe_q, strobe_d;
  logic                 aligned_q, aligned_d;
  logic                 sync_err_q, sync_err_d;
  logic [SPT_WIDTH-1:0] phase_sample_q, phase_sample_d;
  logic [TPP_WIDTH-1:0] phase_turn_q, phase_turn_d;

  logic sync_mode_on, in_phase, accept;
  logic turn_wrap, pt_wrap, fa_wrap, sa_wrap;

  // A programmed count of zero behaves as one.
  assign spt_in = (samplesPerTurn == '0) ? SPT_ONE : samplesPerTurn;
  assign tpp_in = (turnsPerPt == '0) ? TPP_ONE : turnsPerPt;
  assign fad_in = (faDecimate == '0) ? FA_ONE : faDecimate;
  assign sad_in = (saDecimate == '0) ? SA_ONE : saDecimate;

  assign sync_mode_on = (syncMode == 2'd1) || (syncMode == 2'd2);
  assign in_phase     = (sample_cnt_q == '0) && (turn_cnt_q == '0) &&
                        (pt_cnt_q == '0) && (fa_cnt_q == '0);

  always_comb begin
    state_d        = state_q;
    sample_cnt_d   = sample_cnt_q;
    turn_cnt_d     = turn_cnt_q;
    pt_cnt_d       = pt_cnt_q;
    fa_cnt_d       = fa_cnt_q;
    spt_d          = spt_q;
    tpp_d          = tpp_q;
    fad_d          = fad_q;
    sad_d          = sad_q;
    strobe_d       = '0;
    aligned_d      = aligned_q;
    sync_err_d     = 1'b0;
    phase_sample_d = phase_sample_q;
    phase_turn_d   = phase_turn_q;
    eff_state      = state_q;
    spt_cfg        = spt_q;
    tpp_cfg        = tpp_q;
    fad_cfg        = fad_q;
    sad_cfg        = sad_q;
    turn_wrap      = 1'b0;
    pt_wrap        = 1'b0;
    fa_wrap        = 1'b0;
    sa_wrap        = 1'b0;
    accept         = 1'b0;

    if (!enable) begin
      state_d        = ST_IDLE;
      sample_cnt_d   = '0;
      turn_cnt_d     = '0;
      pt_cnt_d       = '0;
      fa_cnt_d       = '0;
      aligned_d      = 1'b0;
      phase_sample_d = '0;
      phase_turn_d   = '0;
    end else begin
      // The enabling cycle already runs with the freshly loaded configuration.
      if (state_q == ST_IDLE) begin
        eff_state = sync_mode_on ? ST_ARMED : ST_RUN;
        spt_cfg   = spt_in;
        tpp_cfg   = tpp_in;
        fad_cfg   = fad_in;
        sad_cfg   = sad_in;
        spt_d     = spt_in;
        tpp_d     = tpp_in;
        fad_d     = fad_in;
        sad_d     = sad_in;
        aligned_d = 1'b0;
      end

      turn_wrap = sampleValid && (sample_cnt_q == spt_cfg - SPT_ONE);
      pt_wrap   = turn_wrap && (turn_cnt_q == tpp_cfg - TPP_ONE);
      fa_wrap   = pt_wrap && (pt_cnt_q == fad_cfg - FA_ONE);
      sa_wrap   = fa_wrap && (fa_cnt_q == sad_cfg - SA_ONE);

      accept = syncIn &&
               (((eff_state == ST_ARMED) && sync_mode_on) ||
                ((eff_state == ST_RUN) && (syncMode == 2'd2) && !in_phase));

      if (accept) begin
        // The coincident sample (if any) becomes sample 0 of the new frame.
        sample_cnt_d = (sampleValid && (spt_in != SPT_ONE)) ? SPT_ONE : '0;
        turn_cnt_d   = '0;
        pt_cnt_d     = '0;
        fa_cnt_d     = '0;
        spt_d        = spt_in;
        tpp_d        = tpp_in;
        fad_d        = fad_in;
        sad_d        = sad_in;
        strobe_d     = 4'b1111;
        aligned_d    = 1'b1;
        state_d      = ST_RUN;
        if (!in_phase) begin
          sync_err_d     = 1'b1;
          phase_sample_d = sample_cnt_q;
          phase_turn_d   = turn_cnt_q;
        end
      end else begin
        if (sampleValid) sample_cnt_d = turn_wrap ? '0 : sample_cnt_q + SPT_ONE;
        if (turn_wrap)   turn_cnt_d   = pt_wrap ? '0 : turn_cnt_q + TPP_ONE;
        if (pt_wrap)     pt_cnt_d     = fa_wrap ? '0 : pt_cnt_q + FA_ONE;
        if (fa_wrap)     fa_cnt_d     = sa_wrap ? '0 : fa_cnt_q + SA_ONE;
        if (sa_wrap) begin
          spt_d = spt_in;
          tpp_d = tpp_in;
          fad_d = fad_in;
          sad_d = sad_in;
        end
        strobe_d = {sa_wrap, fa_wrap, pt_wrap, turn_wrap};
        state_d  = eff_state;
        if ((eff_state == ST_ARMED) && !sync_mode_on) state_d = ST_RUN;
        if ((eff_state == ST_RUN) && (syncMode == 2'd1) && syncArm) begin
          state_d   = ST_ARMED;
          aligned_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      sample_cnt_q   <= '0;
      turn_cnt_q     <= '0;
      pt_cnt_q       <= '0;
      fa_cnt_q       <= '0;
      spt_q          <= SPT_ONE;
      tpp_q          <= TPP_ONE;
      fad_q          <= FA_ONE;
      sad_q          <= SA_ONE;
      strobe_q       <= '0;
      aligned_q      <= 1'b0;
      sync_err_q     <= 1'b0;
      phase_sample_q <= '0;
      phase_turn_q   <= '0;
    end else begin
      state_q        <= state_d;
      sample_cnt_q   <= sample_cnt_d;
      turn_cnt_q     <= turn_cnt_d;
      pt_cnt_q       <= pt_cnt_d;
      fa_cnt_q       <= fa_cnt_d;
      spt_q          <= spt_d;
      tpp_q          <= tpp_d;
      fad_q          <= fad_d;
      sad_q          <= sad_d;
      strobe_q       <= strobe_d;
      aligned_q      <= aligned_d;
      sync_err_q     <= sync_err_d;
      phase_sample_q <= phase_sample_d;
      phase_turn_q   <= phase_turn_d;
    end
  end

  assign turnStrobe  = strobe_q[0];
  assign ptStrobe    = strobe_q[1];
  assign faStrobe    = strobe_q[2];
  assign saStrobe    = strobe_q[3];
  assign ptIndex     = turn_cnt_q;
  assign aligned     = aligned_q;
  assign syncErr     = sync_err_q;
  assign phaseSample = phase_sample_q;
  assign phaseTurn   = phase_turn_q;

endmodule

// File: tb/tb_bpm_rate_strobe_gen.sv
// Directed bench for bpm_rate_strobe_gen: a vector table for the one-shot sync sequence,
// plus arithmetic reference loops for free-run, continuous realign, reconfiguration and reset.
module tb_bpm_rate_strobe_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        sampleValid;
  logic [7:0]  samplesPerTurn;
  logic [5:0]  turnsPerPt;
  logic [9:0]  faDecimate;
  logic [11:0] saDecimate;
  logic [1:0]  syncMode;
  logic        syncArm;
  logic        syncIn;
  logic        turnStrobe, ptStrobe, faStrobe, saStrobe;
  logic [5:0]  ptIndex;
  logic        aligned, syncErr;
  logic [7:0]  phaseSample;
  logic [5:0]  phaseTurn;

  bpm_rate_strobe_gen #(
    .SPT_WIDTH(8), .TPP_WIDTH(6), .FA_WIDTH(10), .SA_WIDTH(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sampleValid(sampleValid),
    .samplesPerTurn(samplesPerTurn), .turnsPerPt(turnsPerPt),
    .faDecimate(faDecimate), .saDecimate(saDecimate),
    .syncMode(syncMode), .syncArm(syncArm), .syncIn(syncIn),
    .turnStrobe(turnStrobe), .ptStrobe(ptStrobe), .faStrobe(faStrobe), .saStrobe(saStrobe),
    .ptIndex(ptIndex), .aligned(aligned), .syncErr(syncErr),
    .phaseSample(phaseSample), .phaseTurn(phaseTurn)
  );

  always #5 clk = ~clk;

  wire [3:0]  str_o = {saStrobe, faStrobe, ptStrobe, turnStrobe};
  wire [25:0] all_o = {str_o, ptIndex, aligned, syncErr, phaseSample, phaseTurn};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit       en;
    bit       sv;
    bit [1:0] mode;
    bit       arm;
    bit       sin;
    bit [3:0] str;
    int       pi;
    bit       al;
    bit       err;
    int       ps;
    int       pt;
  } vec_t;

  vec_t tbl[14];

  // Reference frame model for free-running operation
  int       mn, ms, mt, mf, ma;
  logic [3:0] e_str;
  int       e_pi;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_load();
    ms = (samplesPerTurn == 0) ? 1 : int'(samplesPerTurn);
    mt = (turnsPerPt == 0) ? 1 : int'(turnsPerPt);
    mf = (faDecimate == 0) ? 1 : int'(faDecimate);
    ma = (saDecimate == 0) ? 1 : int'(saDecimate);
    mn = 0;
  endtask

  task automatic mdl_step(input bit v);
    e_str = 4'b0000;
    if (v) begin
      mn++;
      e_str[0] = (mn % ms) == 0;
      e_str[1] = (mn % (ms * mt)) == 0;
      e_str[2] = (mn % (ms * mt * mf)) == 0;
      e_str[3] = mn == (ms * mt * mf * ma);
      if (e_str[3]) begin
        mdl_load();
      end
    end
    e_pi = (mn / ms) % mt;
  endtask

  task automatic set_cfg(input int s, input int t, input int f, input int a, input int mode);
    samplesPerTurn = 8'(s);
    turnsPerPt     = 6'(t);
    faDecimate     = 10'(f);
    saDecimate     = 12'(a);
    syncMode       = 2'(mode);
  endtask

  initial begin
    // en sv mode arm sin | str pi al err ps pt
    tbl[0]  = '{1, 1, 2'd1, 0, 0, 4'b0000, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 2'd1, 0, 0, 4'b0000, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 2'd1, 0, 0, 4'b0000, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 2'd1, 0, 0, 4'b0001, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 2'd1, 0, 0, 4'b0000, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 2'd1, 0, 0, 4'b0000, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 2'd1, 0, 1, 4'b1111, 0, 1, 1, 2, 1};
    tbl[7]  = '{1, 1, 2'd1, 0, 0, 4'b0000, 0, 1, 0, 2, 1};
    tbl[8]  = '{1, 1, 2'd1, 0, 0, 4'b0000, 0, 1, 0, 2, 1};
    tbl[9]  = '{1, 1, 2'd1, 0, 1, 4'b0001, 1, 1, 0, 2, 1};
    tbl[10] = '{1, 1, 2'd1, 1, 0, 4'b0000, 1, 0, 0, 2, 1};
    tbl[11] = '{1, 1, 2'd1, 0, 0, 4'b0000, 1, 0, 0, 2, 1};
    tbl[12] = '{1, 0, 2'd1, 0, 1, 4'b1111, 0, 1, 1, 2, 1};
    tbl[13] = '{1, 1, 2'd1, 0, 0, 4'b0000, 0, 1, 0, 2, 1};

    rst_n = 1'b0;
    enable = 1'b0;
    sampleValid = 1'b0;
    syncArm = 1'b0;
    syncIn = 1'b0;
    set_cfg(4, 3, 2, 2, 0);
    #12;
    chk("reset_outputs", 32'(all_o), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 32'(all_o), 32'h0);

    // Free-run, continuous sampleValid
    enable = 1'b1;
    sampleValid = 1'b1;
    mdl_load();
    for (int c = 1; c <= 100; c++) begin
      step();
      mdl_step(1'b1);
      chk($sformatf("freerun_c%0d", c), 32'({str_o, ptIndex}), 32'({e_str, 6'(e_pi)}));
    end
    $display("[TB] free-run 100 cycles done, ptIndex=%0d", ptIndex);

    // Drop enable mid-frame
    enable = 1'b0;
    step();
    chk("enable_drop_outputs", 32'(all_o), 32'h0);

    // Free-run, sampleValid every other cycle
    enable = 1'b1;
    mdl_load();
    for (int c = 1; c <= 200; c++) begin
      sampleValid = (c % 2) == 1;
      step();
      mdl_step(c % 2 == 1);
      chk($sformatf("halfrate_c%0d", c), 32'({str_o, ptIndex}), 32'({e_str, 6'(e_pi)}));
    end
    $display("[TB] half-rate 200 cycles done");

    // One-shot alignment vectors
    enable = 1'b0;
    sampleValid = 1'b0;
    step();
    set_cfg(4, 3, 2, 2, 1);
    for (int i = 0; i < 14; i++) begin
      enable      = tbl[i].en;
      sampleValid = tbl[i].sv;
      syncMode    = tbl[i].mode;
      syncArm     = tbl[i].arm;
      syncIn      = tbl[i].sin;
      step();
      $display("[TB] vec %0d sv=%0d arm=%0d sin=%0d -> str=%b pi=%0d al=%0d err=%0d ps=%0d pt=%0d",
               i, tbl[i].sv, tbl[i].arm, tbl[i].sin, str_o, ptIndex, aligned, syncErr,
               phaseSample, phaseTurn);
      chk($sformatf("oneshot_vec%0d", i), 32'(all_o),
          32'({tbl[i].str, 6'(tbl[i].pi), tbl[i].al, tbl[i].err, 8'(tbl[i].ps), 6'(tbl[i].pt)}));
    end
    syncArm = 1'b0;
    syncIn = 1'b0;

    // Continuous realign: in-phase syncs every 48, then syncs landing one sample late
    enable = 1'b0;
    step();
    set_cfg(4, 3, 2, 2, 2);
    enable = 1'b1;
    sampleValid = 1'b1;
    begin
      int n, eps, ept;
      bit first, err;
      logic [3:0] estr;
      n = 0; eps = 0; ept = 0; first = 1'b1;
      for (int c = 1; c <= 340; c++) begin
        syncIn = (c <= 145) ? ((c - 1) % 48 == 0) : ((c >= 194) && ((c - 194) % 49 == 0));
        step();
        if (syncIn && (first || (n % 48 != 0))) begin
          err = (n % 48) != 0;
          if (err) begin
            eps = n % 4;
            ept = (n / 4) % 3;
          end
          n = 1;
          estr = 4'b1111;
          first = 1'b0;
        end else begin
          err = 1'b0;
          n++;
          estr = {n % 48 == 0, n % 24 == 0, n % 12 == 0, n % 4 == 0};
        end
        if (syncIn)
          $display("[TB] sync c=%0d err=%0d ps=%0d pt=%0d", c, syncErr, phaseSample, phaseTurn);
        chk($sformatf("realign_c%0d", c), 32'(all_o),
            32'({estr, 6'((n / 4) % 3), 1'b1, err, 8'(eps), 6'(ept)}));
      end
    end
    syncIn = 1'b0;

    // Reconfiguration only takes effect at the SA boundary
    enable = 1'b0;
    step();
    set_cfg(4, 3, 2, 2, 0);
    enable = 1'b1;
    mdl_load();
    for (int c = 1; c <= 140; c++) begin
      if (c == 10)  samplesPerTurn = 8'd6;
      if (c == 100) samplesPerTurn = 8'd0;
      step();
      mdl_step(1'b1);
      chk($sformatf("reconfig_c%0d", c), 32'({str_o, ptIndex}), 32'({e_str, 6'(e_pi)}));
    end
    $display("[TB] reconfiguration 140 cycles done");

    // Asynchronous reset mid-frame
    samplesPerTurn = 8'd4;
    enable = 1'b0;
    step();
    enable = 1'b1;
    for (int c = 1; c <= 30; c++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(all_o), 32'h0);
    step();
    chk("held_reset_outputs", 32'(all_o), 32'h0);
    rst_n = 1'b1;
    mdl_load();
    for (int c = 1; c <= 10; c++) begin
      step();
      mdl_step(1'b1);
      chk($sformatf("post_reset_c%0d", c), 32'({str_o, ptIndex}), 32'({e_str, 6'(e_pi)}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
